digdar_capture_seq: RTL and testbench
=====================================

// Module: digdar_capture_seq
// PURPOSE
//  Per-pulse capture sequencer for the digdar scope datapath. Arms the scope and selects the radar trigger.
//  Waits for the capture window to open and close, then holds the buffer until SW acknowledges readout, then re-arms.
//  Latches per-pulse metadata (clock stamp, ACP/ARP counts) at the accepted radar trigger and counts missed pulses.
//  Sits between the scope bus registers (arm/trig-src mux) and the radar trigger generators.
// PARAMETERS
//  CLK_W   32  width of free-running clock stamp counter
//  ACP_W   16  width of ACP-since-ARP counter
//  ARP_W   16  width of ARP (revolution) counter
//  TO_W    24  width of watchdog counter (used only with DIGDAR_SEQ_TIMEOUT_EN)
// PORTS
//  adc_clk_i      in   1      ADC clock; the only clock
//  adc_rst_i      in   1      asynchronous, active-high reset
//  seq_en_i       in   1      level: 1 = run continuous arm/capture/readout cycles
//  radar_trig_i   in   1      1-cycle radar pulse strobe
//  acp_trig_i     in   1      1-cycle azimuth count pulse strobe
//  arp_trig_i     in   1      1-cycle azimuth reset pulse strobe
//  capturing_i    in   1      scope capture-active flag
//  sw_ack_i       in   1      1-cycle strobe: SW finished reading buffers
//  to_limit_i     in   TO_W   watchdog limit in cycles; 0 disables watchdog
//  arm_o          out  1      1-cycle arm strobe to scope
//  scope_rst_o    out  1      1-cycle scope reset strobe (watchdog only)
//  trig_src_o     out  4      trigger source to scope: 0 none, 2 radar
//  ready_o        out  1      buffer holds a complete pulse awaiting SW
//  busy_o         out  1      state != IDLE
//  stamp_o        out  CLK_W  clock count at accepted trigger
//  acp_o          out  ACP_W  ACP count since last ARP at accepted trigger
//  arp_o          out  ARP_W  ARP count at accepted trigger
//  missed_o       out  32     radar triggers not captured; saturating
//  timeouts_o     out  16     watchdog expiries; saturating
// BEHAVIOUR
//  Reset: state IDLE; every output 0; all counters 0.
//  FSM: IDLE -> ARM when seq_en_i=1.
//   ARM: arm_o=1 and trig_src_o<=2 for one cycle -> WAIT.
//   WAIT: radar_trig_i latches stamp/acp/arp in the same edge. On capturing_i=1 -> CAP.
//   CAP: trig_src_o=0; on capturing_i=0 -> RDY.
//   RDY: ready_o=1; on sw_ack_i -> ARM if seq_en_i else IDLE.
//  Latency: ARM->arm_o is registered (1 cycle). ready_o asserts 1 cycle after capturing_i falls.
//  Metadata is valid while ready_o=1 and is not updated outside WAIT.
//  missed_o increments on radar_trig_i in any state other than WAIT, and on a 2nd trigger in WAIT.
//   Saturates at 2^32-1.
//  Clock counter: free-running, wraps at 2^CLK_W.
//  ACP counter: +1 per acp_trig_i, wraps. arp_trig_i sets it to 0 and increments the ARP counter (wraps).
//   On a simultaneous acp+arp, ARP wins (acp=0).
//  sw_ack_i outside RDY is ignored. seq_en_i falling mid-cycle lets the current capture finish to RDY.
//   After the ack, the FSM goes to IDLE.
//  seq_en_i falling in ARM/WAIT: go to IDLE, drive trig_src_o=0, count no miss.
//  Async reset mid-capture: immediate return to reset values; the scope is re-armed only by a new ARM.
// CONFIGURATION
//  DIGDAR_SEQ_TIMEOUT_EN defined: watchdog counts cycles in WAIT and CAP.
//   On reaching to_limit_i (nonzero), it pulses scope_rst_o for 1 cycle, increments timeouts_o, and goes to ARM.
//   The counter clears on every state change.
//  Undefined: no watchdog logic; scope_rst_o=0 and timeouts_o=0 constantly; to_limit_i is unused.
// STRUCTURE
//  Package digdar_seq_pkg: state enum (IDLE,ARM,WAIT,CAP,RDY) and TRIG_SRC_NONE=4'd0 / TRIG_SRC_RADAR=4'd2.
//  Sub-module digdar_pulse_meta: clock, ACP and ARP counters plus the latch-on-strobe registers.
// TESTING
//  seq_en=1, radar at cycle 20, capturing 22..121, ack at 200:
//   -> arm_o at 2, ready_o 123..200, re-arm next cycle.
//  5 acp, arp, 3 acp, then radar -> acp_o=3, arp_o=1. Simultaneous acp+arp -> acp count 0.
//  3 radar strobes during CAP/RDY -> missed_o=3, metadata unchanged.
//  seq_en=0 during CAP -> completes to RDY; after ack, busy_o=0 and trig_src_o=0.
//  TIMEOUT_EN, to_limit=100, no trigger -> scope_rst_o at WAIT+100, timeouts_o=1, arm_o next cycle.
//  adc_rst_i pulse during CAP -> all outputs 0 asynchronously; restart from IDLE.

Source files
------------

// File: rtl/digdar_seq_pkg.sv
// Shared types for the digdar per-pulse capture sequencer: FSM state encoding
// and the scope trigger-source codes driven onto the scope bus.
package digdar_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    WAIT = 3'd2,
    CAP  = 3'd3,
    RDY  = 3'd4
  } seq_state_e;

  localparam logic [3:0] TRIG_SRC_NONE  = 4'd0;
  localparam logic [3:0] TRIG_SRC_RADAR = 4'd2;

endpackage

// File: rtl/digdar_pulse_meta.sv
// Per-pulse metadata: free-running clock stamp, ACP-since-ARP and ARP counters,
// snapshotted into output registers on latch_i (the accepted radar trigger).
module digdar_pulse_meta #(
  parameter int CLK_W = 32,
  parameter int ACP_W = 16,
  parameter int ARP_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             acp_trig_i,
  input  logic             arp_trig_i,
  input  logic             latch_i,
  output logic [CLK_W-1:0] stamp_o,
  output logic [ACP_W-1:0] acp_o,
  output logic [ARP_W-1:0] arp_o
);

  logic [CLK_W-1:0] clk_cnt_q;
  logic [ACP_W-1:0] acp_cnt_q;
  logic [ARP_W-1:0] arp_cnt_q;
  logic [CLK_W-1:0] stamp_q;
  logic [ACP_W-1:0] acp_q;
  logic [ARP_W-1:0] arp_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_cnt_q <= '0;
      acp_cnt_q <= '0;
      arp_cnt_q <= '0;
      stamp_q   <= '0;
      acp_q     <= '0;
      arp_q     <= '0;
    end else begin
      clk_cnt_q <= clk_cnt_q + CLK_W'(1);
      // ARP restarts the azimuth count even if an ACP lands on the same edge
      if (arp_trig_i) begin
        acp_cnt_q <= '0;
        arp_cnt_q <= arp_cnt_q + ARP_W'(1);
      end else if (acp_trig_i) begin
        acp_cnt_q <= acp_cnt_q + ACP_W'(1);
      end
      if (latch_i) begin
        stamp_q <= clk_cnt_q;
        acp_q   <= acp_cnt_q;
        arp_q   <= arp_cnt_q;
      end
    end
  end

  assign stamp_o = stamp_q;
  assign acp_o   = acp_q;
  assign arp_o   = arp_q;

endmodule

// File: rtl/digdar_capture_seq.sv
// Per-pulse capture sequencer: arm scope, wait for capture window, hold buffer
// until SW ack, re-arm. Optional watchdog enabled by DIGDAR_SEQ_TIMEOUT_EN.
module digdar_capture_seq
  import digdar_seq_pkg::*;
#(
  parameter int CLK_W = 32,
  parameter int ACP_W = 16,
  parameter int ARP_W = 16,
  parameter int TO_W  = 24
) (
  input  logic             adc_clk_i,
  input  logic             adc_rst_i,
  input  logic             seq_en_i,
  input  logic             radar_trig_i,
  input  logic             acp_trig_i,
  input  logic             arp_trig_i,
  input  logic             capturing_i,
  input  logic             sw_ack_i,
  input  logic [TO_W-1:0]  to_limit_i,
  output logic             arm_o,
  output logic             scope_rst_o,
  output logic [3:0]       trig_src_o,
  output logic             ready_o,
  output logic             busy_o,
  output logic [CLK_W-1:0] stamp_o,
  output logic [ACP_W-1:0] acp_o,
  output logic [ARP_W-1:0] arp_o,
  output logic [31:0]      missed_o,
  output logic [15:0]      timeouts_o
);

  seq_state_e  state_q, state_d;
  logic        arm_q;
  logic [3:0]  trig_src_q;
  logic        ready_q;
  logic        got_q;
  logic [31:0] missed_q;
  logic        latch;
  logic        wd_fire;

  // Only the first radar strobe of a WAIT window is accepted
  assign latch = (state_q == WAIT) && radar_trig_i && !got_q;

`ifdef DIGDAR_SEQ_TIMEOUT_EN
  logic [TO_W-1:0] wd_q;
  logic            srst_q;
  logic [15:0]     to_cnt_q;

  assign wd_fire = ((state_q == WAIT) || (state_q == CAP)) && (to_limit_i != '0) &&
                   (({1'b0, wd_q} + (TO_W+1)'(1)) >= {1'b0, to_limit_i});
`else
  logic unused_to;

  assign wd_fire   = 1'b0;
  assign unused_to = ^to_limit_i;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (seq_en_i) state_d = ARM;
      ARM:  state_d = seq_en_i ? WAIT : IDLE;
      WAIT: begin
        if (!seq_en_i)       state_d = IDLE;
        else if (wd_fire)    state_d = ARM;
        else if (capturing_i) state_d = CAP;
      end
      // Dropping seq_en here still lets the capture drain to RDY
      CAP: begin
        if (wd_fire)           state_d = ARM;
        else if (!capturing_i) state_d = RDY;
      end
      RDY:  if (sw_ack_i) state_d = seq_en_i ? ARM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      state_q    <= IDLE;
      arm_q      <= 1'b0;
      trig_src_q <= TRIG_SRC_NONE;
      ready_q    <= 1'b0;
      got_q      <= 1'b0;
      missed_q   <= '0;
`ifdef DIGDAR_SEQ_TIMEOUT_EN
      wd_q       <= '0;
      srst_q     <= 1'b0;
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      arm_q   <= (state_q == ARM) && (state_d == WAIT);
      ready_q <= (state_d == RDY);

      if ((state_q == ARM) && (state_d == WAIT))
        trig_src_q <= TRIG_SRC_RADAR;
      else if ((state_d == IDLE) || (state_d == CAP))
        trig_src_q <= TRIG_SRC_NONE;

      if (state_q == ARM)
        got_q <= 1'b0;
      else if (latch)
        got_q <= 1'b1;

      if (radar_trig_i && !latch && (missed_q != '1))
        missed_q <= missed_q + 32'd1;

`ifdef DIGDAR_SEQ_TIMEOUT_EN
      if ((state_d != state_q) || !((state_q == WAIT) || (state_q == CAP)))
        wd_q <= '0;
      else
        wd_q <= wd_q + TO_W'(1);
      // WAIT/CAP only fall back to ARM through the watchdog
      srst_q <= ((state_q == WAIT) || (state_q == CAP)) && (state_d == ARM);
      if (((state_q == WAIT) || (state_q == CAP)) && (state_d == ARM) && (to_cnt_q != '1))
        to_cnt_q <= to_cnt_q + 16'd1;
`endif
    end
  end

  digdar_pulse_meta #(
    .CLK_W (CLK_W),
    .ACP_W (ACP_W),
    .ARP_W (ARP_W)
  ) u_meta (
    .clk_i      (adc_clk_i),
    .rst_i      (adc_rst_i),
    .acp_trig_i (acp_trig_i),
    .arp_trig_i (arp_trig_i),
    .latch_i    (latch),
    .stamp_o    (stamp_o),
    .acp_o      (acp_o),
    .arp_o      (arp_o)
  );

  assign arm_o      = arm_q;
  assign trig_src_o = trig_src_q;
  assign ready_o    = ready_q;
  assign busy_o     = (state_q != IDLE);
  assign missed_o   = missed_q;

`ifdef DIGDAR_SEQ_TIMEOUT_EN
  assign scope_rst_o = srst_q;
  assign timeouts_o  = to_cnt_q;
`else
  assign scope_rst_o = 1'b0;
  assign timeouts_o  = '0;
`endif

endmodule

// File: tb/tb_digdar_capture_seq.sv
// Bench for digdar_capture_seq: directed pulse scenarios plus random stimulus,
// every output compared each cycle against a behavioural pulse-level model.
`timescale 1ns/1ps
module tb_digdar_capture_seq;

`ifdef DIGDAR_SEQ_TIMEOUT_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  localparam int P_IDLE = 0, P_ARM = 1, P_WAIT = 2, P_CAP = 3, P_RDY = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic        seq_en = 1'b0, radar = 1'b0, acp = 1'b0, arp = 1'b0, cap = 1'b0, ack = 1'b0;
  logic [23:0] to_limit = '0;
  logic        arm, srst, ready, busy;
  logic [3:0]  trig_src;
  logic [31:0] stamp, missed;
  logic [15:0] acp_o, arp_o, timeouts;

  always #5 clk = ~clk;

  digdar_capture_seq dut (
    .adc_clk_i   (clk),
    .adc_rst_i   (rst),
    .seq_en_i    (seq_en),
    .radar_trig_i(radar),
    .acp_trig_i  (acp),
    .arp_trig_i  (arp),
    .capturing_i (cap),
    .sw_ack_i    (ack),
    .to_limit_i  (to_limit),
    .arm_o       (arm),
    .scope_rst_o (srst),
    .trig_src_o  (trig_src),
    .ready_o     (ready),
    .busy_o      (busy),
    .stamp_o     (stamp),
    .acp_o       (acp_o),
    .arp_o       (arp_o),
    .missed_o    (missed),
    .timeouts_o  (timeouts)
  );

  int checks = 0, failures = 0, cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: pulse-level phase, plain counters, expected registered outputs
  int          m_ph, m_wd;
  bit          m_got, m_arm, m_srst;
  logic [3:0]  m_trig;
  logic [31:0] m_clk, m_stamp, m_missed;
  logic [15:0] m_acp, m_arp, m_eacp, m_earp, m_to;

  task automatic model_reset();
    m_ph = P_IDLE; m_wd = 0; m_got = 0; m_arm = 0; m_srst = 0; m_trig = 0;
    m_clk = 0; m_stamp = 0; m_missed = 0; m_acp = 0; m_arp = 0; m_eacp = 0; m_earp = 0; m_to = 0;
  endtask

  task automatic model_step();
    int np;
    bit fire;
    np = m_ph; m_arm = 0; m_srst = 0;
    fire = WD_ON && (to_limit != 0) && (m_wd + 1 >= int'(to_limit)) && (m_ph == P_WAIT || m_ph == P_CAP);
    if (radar) begin
      if (m_ph == P_WAIT && !m_got) begin
        m_stamp = m_clk; m_eacp = m_acp; m_earp = m_arp; m_got = 1;
      end else if (m_missed != 32'hFFFF_FFFF) m_missed++;
    end
    m_clk++;
    if (arp) begin m_acp = 0; m_arp++; end
    else if (acp) m_acp++;
    case (m_ph)
      P_IDLE: if (seq_en) np = P_ARM;
      P_ARM: begin
        if (seq_en) begin np = P_WAIT; m_arm = 1; m_trig = 2; m_got = 0; end
        else begin np = P_IDLE; m_trig = 0; end
      end
      P_WAIT: begin
        if (!seq_en) begin np = P_IDLE; m_trig = 0; end
        else if (fire) begin np = P_ARM; m_srst = 1; end
        else if (cap) begin np = P_CAP; m_trig = 0; end
      end
      P_CAP: begin
        if (fire) begin np = P_ARM; m_srst = 1; end
        else if (!cap) np = P_RDY;
      end
      P_RDY: if (ack) np = seq_en ? P_ARM : P_IDLE;
      default: np = P_IDLE;
    endcase
    if (m_srst && m_to != 16'hFFFF) m_to++;
    m_wd = (np != m_ph || !(m_ph == P_WAIT || m_ph == P_CAP)) ? 0 : m_wd + 1;
    m_ph = np;
  endtask

  task automatic check_all();
    chk("arm", arm, m_arm);
    chk("scope_rst", srst, m_srst);
    chk("trig_src", trig_src, m_trig);
    chk("ready", ready, m_ph == P_RDY);
    chk("busy", busy, m_ph != P_IDLE);
    chk("stamp", stamp, m_stamp);
    chk("acp", acp_o, m_eacp);
    chk("arp", arp_o, m_earp);
    chk("missed", missed, m_missed);
    chk("timeouts", timeouts, m_to);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1; seq_en = 0; radar = 0; acp = 0; arp = 0; cap = 0; ack = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
    cyc = 0;
    check_all();
  endtask

  initial begin
    #400_000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "bench time limit expired");
  end

  initial begin
    // Main pulse: arm, radar at 20, capture 22..121, ack at 200, then re-arm
    do_reset();
    to_limit = '0;
    for (int c = 0; c < 236; c++) begin
      seq_en = (c < 215) || (c >= 236);
      radar  = (c == 20) || (c == 50) || (c == 130) || (c == 150) || (c == 204);
      acp    = (c inside {3, 5, 7, 9, 11, 15, 16, 17, 30});
      arp    = (c == 13) || (c == 30);
      cap    = (c >= 22 && c <= 121) || (c >= 210 && c <= 219);
      ack    = (c == 200) || (c == 230);
      tick();
      case (cyc)
        1:   chk("arm_c1", arm, 1'b0);
        2:   begin chk("arm_c2", arm, 1'b1); chk("trig_radar", trig_src, 4'd2); end
        23:  chk("trig_cap", trig_src, 4'd0);
        122: chk("ready_c122", ready, 1'b0);
        123: begin
          chk("ready_c123", ready, 1'b1); chk("stamp_p1", stamp, 32'd20);
          chk("acp_p1", acp_o, 16'd3);    chk("arp_p1", arp_o, 16'd1);
        end
        200: begin
          chk("ready_c200", ready, 1'b1); chk("missed_3", missed, 32'd3);
          chk("stamp_held", stamp, 32'd20);
        end
        201: chk("ready_c201", ready, 1'b0);
        202: chk("rearm", arm, 1'b1);
        205: begin
          chk("stamp_p2", stamp, 32'd204); chk("acp_simul", acp_o, 16'd0);
          chk("arp_p2", arp_o, 16'd2);
        end
        221: chk("ready_drain", ready, 1'b1);
        231: begin
          chk("busy_off", busy, 1'b0); chk("trig_off", trig_src, 4'd0);
          chk("ready_off", ready, 1'b0);
        end
        default: ;
      endcase
    end

    // seq_en dropped in WAIT -> IDLE, no miss; then restart and capture
    for (int c = 236; c < 276; c++) begin
      seq_en = (c < 240) || (c >= 261);
      radar = 0; acp = (c % 3 == 0); arp = 0; ack = 0;
      cap = (c >= 266);
      tick();
      if (cyc == 241) begin
        chk("wait_abort_busy", busy, 1'b0); chk("wait_abort_trig", trig_src, 4'd0);
        chk("wait_abort_miss", missed, 32'd3);
      end
    end

    // Async reset in the middle of CAP
    #2 rst = 1;
    #1;
    chk("rst_busy", busy, 1'b0);   chk("rst_stamp", stamp, 32'd0);
    chk("rst_missed", missed, 32'd0); chk("rst_arp", arp_o, 16'd0);
    chk("rst_trig", trig_src, 4'd0);  chk("rst_arm", arm, 1'b0);
    @(negedge clk);
    cap = 0; seq_en = 1;
    rst = 0;
    model_reset();
    cyc = 0;
    check_all();
    for (int c = 0; c < 4; c++) begin
      tick();
      if (cyc == 2) chk("rst_rearm", arm, 1'b1);
    end

`ifdef DIGDAR_SEQ_TIMEOUT_EN
    do_reset();
    to_limit = 24'd100;
    seq_en = 1;
    for (int c = 0; c < 106; c++) begin
      tick();
      case (cyc)
        101: chk("wd_early", srst, 1'b0);
        102: begin chk("wd_fire", srst, 1'b1); chk("wd_count", timeouts, 16'd1); end
        103: chk("wd_rearm", arm, 1'b1);
        default: ;
      endcase
    end
`endif

    // Random traffic against the model
    do_reset();
    to_limit = 24'd37;
    seq_en = 1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(79) == 0) seq_en = ~seq_en;
      if ($urandom_range(9) == 0) cap = ~cap;
      radar = ($urandom_range(11) == 0);
      acp   = ($urandom_range(3) == 0);
      arp   = ($urandom_range(29) == 0);
      ack   = ($urandom_range(7) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
